// File: rtl/mosby_pkg.sv
// Shared definitions for the mosby fetch path: constants, fetch state encoding
// and the redirect address helper.
package mosby_pkg;

    localparam logic [7:0]  NOP          = 8'hEA;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
    localparam int          FIFO_DEPTH   = 2;
    localparam int          CNT_W        = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2,
        FLUSH  = 2'd3
    } fetch_state_t;

    // A page-local redirect keeps the current page and swaps only the low byte.
    function automatic logic [15:0] redirect_addr(input logic [15:0] cur_pc,
                                                  input logic [15:0] target,
                                                  input logic        lower_byte);
        return lower_byte ? {cur_pc[15:8], target[7:0]} : target;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small byte FIFO holding prefetched instruction bytes ahead of the decoder.
module prefetch_fifo
    import mosby_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_2,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still accepts a push when the same cycle pops the head.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_2) begin
        if (push_ok && !rst && !clear)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_2) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads the reset vector, then streams bytes into a small
// prefetch buffer and hands them to the decoder, honouring branch redirects.
module fetch_unit
    import mosby_pkg::*;
(
    input  logic        clk_2,
    input  logic        rst,
    input  logic        increment,
    input  logic        branch_uncon,
    input  logic        branch_con,
    input  logic        cond_met,
    input  logic        lower_byte,
    input  logic [15:0] branch_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic [7:0]  instruction,
    output logic        normal,
    output logic        flush,
    output logic [15:0] pc
);

    fetch_state_t     state;
    logic [7:0]       vec_lo;
    logic [15:0]      fetch_ptr;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             taken, push, pop;

    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign taken     = (state == RUN) && (branch_uncon || (branch_con && cond_met));

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = RESET_VECTOR;
        if (!rst) begin
            case (state)
                VEC_LO: begin mem_req = 1'b1; mem_addr = RESET_VECTOR; end
                VEC_HI: begin mem_req = 1'b1; mem_addr = RESET_VECTOR + 16'd1; end
                RUN:    begin mem_req = !fifo_full; mem_addr = fetch_ptr; end
                default: begin mem_req = 1'b0; mem_addr = fetch_ptr; end
            endcase
        end
    end

    // A redirect wins over both ends of the FIFO; the byte landing that cycle is dropped.
    assign push        = (state == RUN) && mem_req && mem_ready && !taken;
    assign pop         = (state == RUN) && increment && normal && !taken && !rst;
    assign normal      = !rst && (fifo_count != '0);
    assign instruction = normal ? fifo_head : NOP;

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state     <= VEC_LO;
            vec_lo    <= 8'h00;
            pc        <= 16'h0000;
            fetch_ptr <= 16'h0000;
            flush     <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                VEC_LO: if (mem_ready) begin
                    vec_lo <= mem_data;
                    state  <= VEC_HI;
                end
                VEC_HI: if (mem_ready) begin
                    pc        <= {mem_data, vec_lo};
                    fetch_ptr <= {mem_data, vec_lo};
                    state     <= RUN;
                end
                RUN: begin
                    if (taken) begin
                        pc        <= redirect_addr(pc, branch_target, lower_byte);
                        fetch_ptr <= redirect_addr(pc, branch_target, lower_byte);
                        flush     <= 1'b1;
                        state     <= FLUSH;
                    end else begin
                        if (push) fetch_ptr <= fetch_ptr + 16'd1;
                        if (pop)  pc        <= pc + 16'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    prefetch_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk_2 (clk_2),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (taken),
        .din   (mem_data),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational byte memory model.
module tb_fetch_unit;
    logic        clk_2 = 1'b0;
    logic        rst, increment, branch_uncon, branch_con, cond_met, lower_byte;
    logic [15:0] branch_target;
    logic        mem_req, mem_ready, normal, flush;
    logic [15:0] mem_addr, pc;
    logic [7:0]  mem_data, instruction;
    logic [7:0]  mem [0:65535];
    int          tests = 0;
    int          fails = 0;

    always #5 clk_2 = ~clk_2;
    assign mem_data = mem[mem_addr];

    fetch_unit dut (
        .clk_2(clk_2), .rst(rst), .increment(increment),
        .branch_uncon(branch_uncon), .branch_con(branch_con), .cond_met(cond_met),
        .lower_byte(lower_byte), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .instruction(instruction), .normal(normal), .flush(flush), .pc(pc)
    );

    task automatic clear_inputs();
        increment = 0; branch_uncon = 0; branch_con = 0; cond_met = 0;
        lower_byte = 0; branch_target = 16'h0000;
    endtask

    task automatic boot(input logic [7:0] lo, input logic [7:0] hi);
        @(negedge clk_2);
        rst = 1; mem_ready = 0; clear_inputs();
        mem[16'hFFFC] = lo; mem[16'hFFFD] = hi;
        @(negedge clk_2);
        rst = 0; mem_ready = 1;
        repeat (2) @(negedge clk_2);
    endtask

    task automatic test_reset();
        rst = 1; mem_ready = 0; clear_inputs();
        repeat (2) @(negedge clk_2);
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        tests++; if (normal !== 1'b0) begin fails++; $display("FAIL reset_normal got %b exp 0", normal); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush); end
        tests++; if (instruction !== 8'hEA) begin fails++; $display("FAIL reset_instr got %h exp ea", instruction); end
        tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h exp 0000", pc); end
        tests++; if (mem_addr !== 16'hFFFC) begin fails++; $display("FAIL reset_addr got %h exp fffc", mem_addr); end
        tests++; if (dut.u_fifo.count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", dut.u_fifo.count); end
    endtask

    task automatic test_vector();
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        rst = 0; mem_ready = 1;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFC) begin fails++; $display("FAIL vec_lo req %b addr %h exp 1 fffc", mem_req, mem_addr); end
        @(negedge clk_2);
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFD) begin fails++; $display("FAIL vec_hi req %b addr %h exp 1 fffd", mem_req, mem_addr); end
        @(negedge clk_2);
        tests++; if (pc !== 16'h8000 || mem_addr !== 16'h8000) begin fails++; $display("FAIL vec_run pc %h addr %h exp 8000 8000", pc, mem_addr); end
        tests++; if (normal !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL vec_empty normal %b req %b exp 0 1", normal, mem_req); end
        // Pop on empty buffer, memory stalled: nothing may move.
        mem_ready = 0; increment = 1;
        @(negedge clk_2);
        tests++; if (pc !== 16'h8000 || normal !== 1'b0 || mem_addr !== 16'h8000) begin fails++; $display("FAIL empty_pop pc %h normal %b addr %h exp 8000 0 8000", pc, normal, mem_addr); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h69; exp_b[1] = 8'h05; exp_b[2] = 8'hEA; exp_b[3] = 8'hEA;
        mem_ready = 1; increment = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_2);
            tests++;
            if (instruction !== exp_b[i] || pc !== 16'h8000 + 16'(i) || normal !== 1'b1 || dut.u_fifo.count > 2'd2) begin
                fails++;
                $display("FAIL stream[%0d] instr %h pc %h normal %b cnt %0d exp %h %h 1 <=2", i, instruction, pc, normal, dut.u_fifo.count, exp_b[i], 16'h8000 + 16'(i));
            end
        end
        increment = 0;
    endtask

    task automatic test_backpressure();
        boot(8'h00, 8'h80);
        repeat (3) @(negedge clk_2);
        tests++; if (dut.u_fifo.count !== 2'd2 || mem_req !== 1'b0 || mem_addr !== 16'h8002) begin fails++; $display("FAIL bp_full cnt %0d req %b addr %h exp 2 0 8002", dut.u_fifo.count, mem_req, mem_addr); end
        tests++; if (instruction !== 8'h69 || pc !== 16'h8000) begin fails++; $display("FAIL bp_head instr %h pc %h exp 69 8000", instruction, pc); end
        increment = 1;
        @(negedge clk_2);
        increment = 0;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h8002 || instruction !== 8'h05 || pc !== 16'h8001) begin fails++; $display("FAIL bp_pop req %b addr %h instr %h pc %h exp 1 8002 05 8001", mem_req, mem_addr, instruction, pc); end
    endtask

    task automatic test_redirect();
        mem_ready = 0; branch_con = 1; cond_met = 0; branch_target = 16'h9010;
        @(negedge clk_2);
        tests++; if (flush !== 1'b0 || pc !== 16'h8001 || mem_addr !== 16'h8002 || instruction !== 8'h05) begin fails++; $display("FAIL br_not_taken flush %b pc %h addr %h instr %h exp 0 8001 8002 05", flush, pc, mem_addr, instruction); end
        mem[16'h9010] = 8'hA9;
        cond_met = 1; mem_ready = 1; increment = 1;
        @(negedge clk_2);
        clear_inputs();
        tests++; if (flush !== 1'b1 || normal !== 1'b0 || mem_req !== 1'b0 || instruction !== 8'hEA) begin fails++; $display("FAIL br_flush flush %b normal %b req %b instr %h exp 1 0 0 ea", flush, normal, mem_req, instruction); end
        tests++; if (pc !== 16'h9010 || dut.u_fifo.count !== 2'd0) begin fails++; $display("FAIL br_pc pc %h cnt %0d exp 9010 0", pc, dut.u_fifo.count); end
        @(negedge clk_2);
        tests++; if (flush !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h9010 || normal !== 1'b0) begin fails++; $display("FAIL br_refetch flush %b req %b addr %h normal %b exp 0 1 9010 0", flush, mem_req, mem_addr, normal); end
        @(negedge clk_2);
        tests++; if (instruction !== 8'hA9 || pc !== 16'h9010 || dut.u_fifo.count !== 2'd1) begin fails++; $display("FAIL br_first instr %h pc %h cnt %0d exp a9 9010 1", instruction, pc, dut.u_fifo.count); end
    endtask

    task automatic test_page_and_wrap();
        boot(8'hF0, 8'h12);
        branch_uncon = 1; lower_byte = 1; branch_target = 16'hAB34;
        @(negedge clk_2);
        clear_inputs();
        tests++; if (pc !== 16'h1234 || mem_addr !== 16'h1234 || flush !== 1'b1 || dut.u_fifo.count !== 2'd0) begin fails++; $display("FAIL page pc %h addr %h flush %b cnt %0d exp 1234 1234 1 0", pc, mem_addr, flush, dut.u_fifo.count); end
        mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h20;
        boot(8'hFF, 8'hFF);
        tests++; if (mem_addr !== 16'hFFFF || pc !== 16'hFFFF) begin fails++; $display("FAIL wrap_start addr %h pc %h exp ffff ffff", mem_addr, pc); end
        @(negedge clk_2);
        tests++; if (mem_addr !== 16'h0000 || instruction !== 8'h4C) begin fails++; $display("FAIL wrap_ptr addr %h instr %h exp 0000 4c", mem_addr, instruction); end
        increment = 1;
        @(negedge clk_2);
        increment = 0;
        tests++; if (pc !== 16'h0000 || instruction !== 8'h20) begin fails++; $display("FAIL wrap_pc pc %h instr %h exp 0000 20", pc, instruction); end
    endtask

    task automatic test_mid_reset();
        boot(8'h00, 8'h80);
        repeat (2) @(negedge clk_2);
        tests++; if (dut.u_fifo.count !== 2'd2) begin fails++; $display("FAIL mr_fill cnt %0d exp 2", dut.u_fifo.count); end
        rst = 1;
        @(negedge clk_2);
        tests++; if (normal !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'hFFFC || pc !== 16'h0000 || dut.u_fifo.count !== 2'd0) begin fails++; $display("FAIL mr_reset normal %b req %b addr %h pc %h cnt %0d exp 0 0 fffc 0000 0", normal, mem_req, mem_addr, pc, dut.u_fifo.count); end
        rst = 0; mem_ready = 0; branch_uncon = 1; branch_target = 16'h1111;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFC) begin fails++; $display("FAIL mr_veclo req %b addr %h exp 1 fffc", mem_req, mem_addr); end
        @(negedge clk_2);
        clear_inputs();
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFC || pc !== 16'h0000 || flush !== 1'b0) begin fails++; $display("FAIL mr_stall req %b addr %h pc %h flush %b exp 1 fffc 0000 0", mem_req, mem_addr, pc, flush); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
        mem[16'h8000] = 8'h69; mem[16'h8001] = 8'h05;
        mem[16'h8002] = 8'hEA; mem[16'h8003] = 8'hEA;
        rst = 1; mem_ready = 0; clear_inputs();
        test_reset();
        test_vector();
        test_stream();
        test_backpressure();
        test_redirect();
        test_page_and_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
